prog_sqr_wave_multi: RTL and testbench

Multi-channel programmable square-wave/pulse generator. Each channel drives a high phase of m time units, then a low phase of n time units. One time unit is TICK_DIV clock cycles. Adds per-channel enable, continuous and one-shot modes, glitch-free parameter update at period boundaries, and busy/done status. Sits beside the single-channel generator for LED/PWM/strobe timing.

---
 rtl/prog_sqr_wave_multi.sv | 174 +++++++++++++++++
 tb/tb_prog_sqr_wave_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sqr_wave_multi.sv
// Multi-channel programmable square-wave/pulse generator: each channel emits m units high then n units low,
// with one unit set by a shared prescaler, in continuous or one-shot mode, with busy/done status.
module prog_sqr_wave_multi #(
   parameter int CH       = 4,
   parameter int W        = 4,
   parameter int TICK_DIV = 10
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [CH-1:0]   en_i,
   input  logic [CH-1:0]   mode_i,
   input  logic [CH-1:0]   start_i,
   input  logic [CH*W-1:0] m_i,
   input  logic [CH*W-1:0] n_i,
   output logic [CH-1:0]   out_o,
   output logic [CH-1:0]   busy_o,
   output logic [CH-1:0]   done_o
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [W-1:0]  ONE = W'(1);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } chState_e;

   logic [PW-1:0] prescQ, prescD;
   logic          tick;

   chState_e      stateQ [CH];
   chState_e      stateD [CH];
   logic [W-1:0]  cntQ [CH];
   logic [W-1:0]  cntD [CH];
   logic [W-1:0]  mLQ [CH];
   logic [W-1:0]  mLD [CH];
   logic [W-1:0]  nLQ [CH];
   logic [W-1:0]  nLD [CH];
   logic [CH-1:0] pendingQ, pendingD;
   logic [CH-1:0] outQ, outD;
   logic [CH-1:0] busyQ, busyD;
   logic [CH-1:0] doneQ, doneD;

   assign tick   = (prescQ == PRESC_LAST);
   assign prescD = tick ? '0 : prescQ + PW'(1);

   // Period end either chains straight into a new period start (continuous, still enabled) or parks in IDLE.
   always_comb begin
      pendingD = pendingQ;
      doneD    = '0;
      outD     = '0;
      busyD    = '0;
      for (int i = 0; i < CH; i++) begin : chNext
         logic doStart;
         logic doEnd;
         logic consumed;
         logic [W-1:0] mIn;
         logic [W-1:0] nIn;
         doStart   = 1'b0;
         doEnd     = 1'b0;
         consumed  = 1'b0;
         mIn       = m_i[i*W +: W];
         nIn       = n_i[i*W +: W];
         stateD[i] = stateQ[i];
         cntD[i]   = cntQ[i];
         mLD[i]    = mLQ[i];
         nLD[i]    = nLQ[i];

         if (tick) begin
            case (stateQ[i])
               IDLE: begin
                  if (!mode_i[i] && en_i[i]) begin
                     doStart = 1'b1;
                  end else if (mode_i[i] && pendingQ[i]) begin
                     consumed    = 1'b1;
                     pendingD[i] = 1'b0;
                     doStart     = 1'b1;
                  end
               end
               HIGH: begin
                  if (cntQ[i] == mLQ[i] - ONE) begin
                     if (nLQ[i] != '0) begin
                        stateD[i] = LOW;
                        cntD[i]   = '0;
                     end else begin
                        doEnd = 1'b1;
                     end
                  end else begin
                     cntD[i] = cntQ[i] + ONE;
                  end
               end
               LOW: begin
                  if (cntQ[i] == nLQ[i] - ONE) begin
                     doEnd = 1'b1;
                  end else begin
                     cntD[i] = cntQ[i] + ONE;
                  end
               end
               default: stateD[i] = IDLE;
            endcase
         end

         if (doEnd) begin
            stateD[i] = IDLE;
            cntD[i]   = '0;
            if (mode_i[i]) begin
               doneD[i] = 1'b1;
            end else if (en_i[i]) begin
               doStart = 1'b1;
            end
         end

         // A zero-length period is a complete period in itself, so a one-shot still reports done.
         if (doStart) begin
            mLD[i]  = mIn;
            nLD[i]  = nIn;
            cntD[i] = '0;
            if (mIn != '0) begin
               stateD[i] = HIGH;
            end else if (nIn != '0) begin
               stateD[i] = LOW;
            end else begin
               stateD[i] = IDLE;
               if (mode_i[i]) begin
                  doneD[i] = 1'b1;
               end
            end
         end

         if ((stateQ[i] == IDLE) && mode_i[i] && start_i[i] && !consumed) begin
            pendingD[i] = 1'b1;
         end

         outD[i]  = (stateD[i] == HIGH);
         busyD[i] = (stateD[i] != IDLE);
      end
   end

   // Single synchronous reset point for the prescaler and all channel state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prescQ   <= '0;
         pendingQ <= '0;
         outQ     <= '0;
         busyQ    <= '0;
         doneQ    <= '0;
         for (int i = 0; i < CH; i++) begin
            stateQ[i] <= IDLE;
            cntQ[i]   <= '0;
            mLQ[i]    <= '0;
            nLQ[i]    <= '0;
         end
      end else begin
         prescQ   <= prescD;
         pendingQ <= pendingD;
         outQ     <= outD;
         busyQ    <= busyD;
         doneQ    <= doneD;
         for (int i = 0; i < CH; i++) begin
            stateQ[i] <= stateD[i];
            cntQ[i]   <= cntD[i];
            mLQ[i]    <= mLD[i];
            nLQ[i]    <= nLD[i];
         end
      end
   end

   assign out_o  = outQ;
   assign busy_o = busyQ;
   assign done_o = doneQ;

endmodule

// File: tb/tb_prog_sqr_wave_multi.sv
// Testbench for prog_sqr_wave_multi: absolute-time reference model compared every cycle,
// plus hand-computed cycle checks for the directed scenarios.
`timescale 1ns/1ps
module tb_prog_sqr_wave_multi;

   localparam int CH = 2;
   localparam int W  = 4;
   localparam int TD = 10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [CH-1:0]   en = '0;
   logic [CH-1:0]   mode = '0;
   logic [CH-1:0]   start = '0;
   logic [CH*W-1:0] m = '0;
   logic [CH*W-1:0] n = '0;
   logic [CH-1:0]   dutOut;
   logic [CH-1:0]   dutBusy;
   logic [CH-1:0]   dutDone;

   int total = 0;
   int bad = 0;
   int tbCyc = 0;
   bit checkOn = 1'b0;

   prog_sqr_wave_multi #(.CH(CH), .W(W), .TICK_DIV(TD)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (en),
      .mode_i  (mode),
      .start_i (start),
      .m_i     (m),
      .n_i     (n),
      .out_o   (dutOut),
      .busy_o  (dutBusy),
      .done_o  (dutDone)
   );

   always #5 clk = ~clk;

   // Cycle index since the most recent reset edge; cycle 0 is the first cycle after reset.
   always @(posedge clk) begin
      if (rst) tbCyc <= 0;
      else     tbCyc <= tbCyc + 1;
   end

   // Reference model: a running period is described by the absolute edge numbers where it falls and ends.
   int pm = 0;
   int edgeNum = 0;
   bit act [CH];
   bit pend [CH];
   int hiEnd [CH];
   int loEnd [CH];
   logic [CH-1:0] expOut = '0;
   logic [CH-1:0] expBusy = '0;
   logic [CH-1:0] expDone = '0;

   always @(posedge clk) begin
      bit tick;
      bit wasIdle;
      bit consumed;
      bit doStart;
      bit ended;
      int mL;
      int nL;
      edgeNum = edgeNum + 1;
      tick = (pm == TD - 1);
      if (rst) begin
         pm = 0;
         for (int i = 0; i < CH; i++) begin
            act[i] = 1'b0;
            pend[i] = 1'b0;
         end
         expOut = '0;
         expBusy = '0;
         expDone = '0;
      end else begin
         pm = (pm + 1) % TD;
         for (int i = 0; i < CH; i++) begin
            wasIdle = !act[i];
            consumed = 1'b0;
            doStart = 1'b0;
            ended = 1'b0;
            expDone[i] = 1'b0;
            if (act[i]) begin
               if (edgeNum == loEnd[i]) begin
                  act[i] = 1'b0;
                  ended = 1'b1;
               end
            end else if (tick) begin
               if (!mode[i] && en[i]) begin
                  doStart = 1'b1;
               end else if (mode[i] && pend[i]) begin
                  pend[i] = 1'b0;
                  consumed = 1'b1;
                  doStart = 1'b1;
               end
            end
            if (ended) begin
               if (mode[i]) expDone[i] = 1'b1;
               else if (en[i]) doStart = 1'b1;
            end
            if (doStart) begin
               mL = int'(m[i*W +: W]);
               nL = int'(n[i*W +: W]);
               if (mL + nL == 0) begin
                  act[i] = 1'b0;
                  if (mode[i]) expDone[i] = 1'b1;
               end else begin
                  act[i] = 1'b1;
                  hiEnd[i] = edgeNum + mL * TD;
                  loEnd[i] = hiEnd[i] + nL * TD;
               end
            end
            if (wasIdle && mode[i] && start[i] && !consumed) pend[i] = 1'b1;
            expOut[i] = act[i] && (edgeNum < hiEnd[i]);
            expBusy[i] = act[i];
         end
      end
   end

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, actual, expected, tbCyc);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkOn) begin
         for (int i = 0; i < CH; i++) begin
            checkOutput($sformatf("model_out%0d", i), dutOut[i], expOut[i]);
            checkOutput($sformatf("model_busy%0d", i), dutBusy[i], expBusy[i]);
            checkOutput($sformatf("model_done%0d", i), dutDone[i], expDone[i]);
         end
      end
   end

   task automatic applyStimulus(input int ch, input logic enV, input logic modeV,
                                input logic [W-1:0] mV, input logic [W-1:0] nV);
      en[ch] = enV;
      mode[ch] = modeV;
      m[ch*W +: W] = mV;
      n[ch*W +: W] = nV;
   endtask

   task automatic pulseStart(input int ch);
      start[ch] = 1'b1;
      @(negedge clk);
      start[ch] = 1'b0;
   endtask

   task automatic waitUntil(input int c);
      int guard;
      guard = 0;
      while (tbCyc < c && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (tbCyc != c) begin
         total++;
         bad++;
         $display("[TB] FAIL wait_cycle: got %0d expected %0d", tbCyc, c);
      end
   endtask

   initial begin
      #200000;
      bad++;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      checkOn = 1'b1;
      checkOutput("reset_out0", dutOut[0], 1'b0);
      checkOutput("reset_busy0", dutBusy[0], 1'b0);
      checkOutput("reset_done1", dutDone[1], 1'b0);

      // Scenario 1: ch0 continuous m=1 n=2 released at cycle 0
      rst = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 4'd1, 4'd2);
      waitUntil(9);   checkOutput("s1_out_c9", dutOut[0], 1'b0);
      waitUntil(10);  checkOutput("s1_out_c10", dutOut[0], 1'b1);
                      checkOutput("s1_busy_c10", dutBusy[0], 1'b1);
      waitUntil(19);  checkOutput("s1_out_c19", dutOut[0], 1'b1);
      waitUntil(20);  checkOutput("s1_out_c20", dutOut[0], 1'b0);
      waitUntil(39);  checkOutput("s1_out_c39", dutOut[0], 1'b0);
      waitUntil(40);  checkOutput("s1_out_c40", dutOut[0], 1'b1);

      // Scenario 2: change to m=3 n=1 mid-high; takes effect at the next period
      waitUntil(72);  applyStimulus(0, 1'b1, 1'b0, 4'd3, 4'd1);
      waitUntil(79);  checkOutput("s2_out_c79", dutOut[0], 1'b1);
      waitUntil(80);  checkOutput("s2_out_c80", dutOut[0], 1'b0);
      waitUntil(99);  checkOutput("s2_out_c99", dutOut[0], 1'b0);
      waitUntil(100); checkOutput("s2_out_c100", dutOut[0], 1'b1);
      waitUntil(129); checkOutput("s2_out_c129", dutOut[0], 1'b1);
      waitUntil(130); checkOutput("s2_out_c130", dutOut[0], 1'b0);
      waitUntil(140); checkOutput("s2_out_c140", dutOut[0], 1'b1);

      // Scenario 3: drop en mid-low; period completes then idles
      waitUntil(172); applyStimulus(0, 1'b0, 1'b0, 4'd3, 4'd1);
      waitUntil(179); checkOutput("s3_busy_c179", dutBusy[0], 1'b1);
      waitUntil(180); checkOutput("s3_busy_c180", dutBusy[0], 1'b0);
                      checkOutput("s3_out_c180", dutOut[0], 1'b0);
      waitUntil(200); checkOutput("s3_out_c200", dutOut[0], 1'b0);

      // Scenario 4: ch1 one-shot m=2 n=1, retrigger while busy ignored
      waitUntil(205); applyStimulus(1, 1'b0, 1'b1, 4'd2, 4'd1);
      pulseStart(1);
      waitUntil(209); checkOutput("s4_out_c209", dutOut[1], 1'b0);
      waitUntil(210); checkOutput("s4_out_c210", dutOut[1], 1'b1);
      waitUntil(215); pulseStart(1);
      waitUntil(229); checkOutput("s4_out_c229", dutOut[1], 1'b1);
      waitUntil(230); checkOutput("s4_out_c230", dutOut[1], 1'b0);
      waitUntil(239); checkOutput("s4_busy_c239", dutBusy[1], 1'b1);
                      checkOutput("s4_done_c239", dutDone[1], 1'b0);
      waitUntil(240); checkOutput("s4_done_c240", dutDone[1], 1'b1);
                      checkOutput("s4_busy_c240", dutBusy[1], 1'b0);
      waitUntil(241); checkOutput("s4_done_c241", dutDone[1], 1'b0);
      waitUntil(250); checkOutput("s4_out_c250", dutOut[1], 1'b0);
      // start coinciding with a tick is serviced at the following tick
      waitUntil(259); pulseStart(1);
      waitUntil(269); checkOutput("s4_out_c269", dutOut[1], 1'b0);
      waitUntil(270); checkOutput("s4_out_c270", dutOut[1], 1'b1);
      waitUntil(300); checkOutput("s4_done_c300", dutDone[1], 1'b1);

      // Scenario 5: degenerate lengths on ch0
      waitUntil(310); applyStimulus(0, 1'b1, 1'b0, 4'd0, 4'd5);
      waitUntil(400); checkOutput("s5a_out", dutOut[0], 1'b0);
                      checkOutput("s5a_busy", dutBusy[0], 1'b1);
      waitUntil(500); applyStimulus(0, 1'b1, 1'b0, 4'd4, 4'd0);
      waitUntil(700); checkOutput("s5b_out", dutOut[0], 1'b1);
                      checkOutput("s5b_busy", dutBusy[0], 1'b1);
      applyStimulus(0, 1'b1, 1'b0, 4'd0, 4'd0);
      waitUntil(900); checkOutput("s5c_out", dutOut[0], 1'b0);
                      checkOutput("s5c_busy", dutBusy[0], 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 4'd0, 4'd0);

      // Scenario 6: reset during a ch1 one-shot high phase, then ch0 restarts
      waitUntil(905); pulseStart(1);
      waitUntil(912); checkOutput("s6_out1_c912", dutOut[1], 1'b1);
      waitUntil(915); rst = 1'b1;
      @(negedge clk);
      checkOutput("s6_out1_rst", dutOut[1], 1'b0);
      checkOutput("s6_busy1_rst", dutBusy[1], 1'b0);
      checkOutput("s6_done1_rst", dutDone[1], 1'b0);
      rst = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 4'd1, 4'd2);
      waitUntil(9);   checkOutput("s6_out_c9", dutOut[0], 1'b0);
      waitUntil(10);  checkOutput("s6_out_c10", dutOut[0], 1'b1);
      waitUntil(20);  checkOutput("s6_out_c20", dutOut[0], 1'b0);
                      checkOutput("s6_out1_c20", dutOut[1], 1'b0);
      waitUntil(40);  checkOutput("s6_out_c40", dutOut[0], 1'b1);
      waitUntil(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
